jtframe_status_spi: RTL and testbench

SPI-slave front end that builds the 64-bit OSD `status` word and the 7-bit `core_mod` word consumed by the DIP/OSD decoder. It receives commands from the I/O controller over a 3-wire-plus-select serial link, oversampled in the core clock domain. It updates its outputs atomically only after a complete, valid frame, and can serialise the current status word back for verification.

---
 rtl/jtframe_status_pkg.sv | 35 +++
 rtl/jtframe_spi_sync.sv | 49 ++++
 rtl/jtframe_status_spi.sv | 189 ++++++++++++++++++
 tb/tb_jtframe_status_spi.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_status_pkg.sv
// Shared constants, FSM state type and helpers for the OSD status SPI slave.
package jtframe_status_pkg;

    localparam int ST_W = 64;

    localparam logic [7:0] CMD_ST32 = 8'h14;
    localparam logic [7:0] CMD_ST64 = 8'h1E;
    localparam logic [7:0] CMD_MOD  = 8'h21;
    localparam logic [7:0] CMD_STRD = 8'h1F;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WR,
        S_RD,
        S_IGNORE
    } state_t;

    // Index of the final payload byte for each write command.
    function automatic logic [2:0] last_byte(input logic [7:0] cmd);
        case (cmd)
            CMD_ST32: last_byte = 3'd3;
            CMD_ST64: last_byte = 3'd7;
            default:  last_byte = 3'd0;
        endcase
    endfunction

    // Reorder so that shifting out MSB-first yields LSB byte first.
    function automatic logic [ST_W-1:0] byte_swap(input logic [ST_W-1:0] v);
        for (int k = 0; k < ST_W/8; k++) begin
            byte_swap[ST_W-1-8*k -: 8] = v[8*k +: 8];
        end
    endfunction

endpackage

// File: rtl/jtframe_spi_sync.sv
// Synchronises the asynchronous SPI pins into clk and derives edge strobes.
module jtframe_spi_sync #(
    parameter int SYNC = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic spi_ss_n,
    input  logic spi_sck,
    input  logic spi_mosi,
    output logic ss_act,
    output logic ss_fall,
    output logic ss_rise,
    output logic sck_rise,
    output logic sck_fall,
    output logic mosi_s
);

    logic [SYNC-1:0] ss_q;
    logic [SYNC-1:0] sck_q;
    logic [SYNC-1:0] mosi_q;
    logic            ss_dly_q;
    logic            sck_dly_q;

    // Select resets to "asserted" so a frame already in progress when reset
    // releases cannot produce a start edge; only a real high-then-low does.
    always_ff @(posedge clk) begin
        if (rst) begin
            ss_q      <= '0;
            sck_q     <= '0;
            mosi_q    <= '0;
            ss_dly_q  <= 1'b0;
            sck_dly_q <= 1'b0;
        end else begin
            ss_q      <= {ss_q[SYNC-2:0], spi_ss_n};
            sck_q     <= {sck_q[SYNC-2:0], spi_sck};
            mosi_q    <= {mosi_q[SYNC-2:0], spi_mosi};
            ss_dly_q  <= ss_q[SYNC-1];
            sck_dly_q <= sck_q[SYNC-1];
        end
    end

    assign ss_act   = ~ss_q[SYNC-1];
    assign ss_fall  = ~ss_q[SYNC-1] &  ss_dly_q;
    assign ss_rise  =  ss_q[SYNC-1] & ~ss_dly_q;
    assign sck_rise =  sck_q[SYNC-1] & ~sck_dly_q;
    assign sck_fall = ~sck_q[SYNC-1] &  sck_dly_q;
    assign mosi_s   =  mosi_q[SYNC-1];

endmodule

// File: rtl/jtframe_status_spi.sv
// SPI slave building the OSD status and core_mod words, with atomic commit
// after a complete frame and serial readback of the status word.
//
//   state    | meaning
//   S_IDLE   | waiting for select to fall
//   S_CMD    | shifting in the command byte
//   S_WR     | collecting payload bytes into the shadow
//   S_RD     | shifting the status copy out on miso
//   S_IGNORE | unknown command or payload done; wait for select rise
module jtframe_status_spi
    import jtframe_status_pkg::*;
#(
    parameter int         SYNC    = 2,
    parameter logic [6:0] MOD_DEF = 7'h00
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            spi_ss_n,
    input  logic            spi_sck,
    input  logic            spi_mosi,
    output logic            spi_miso,
    output logic [ST_W-1:0] status,
    output logic [6:0]      core_mod,
    output logic            status_upd,
    output logic            mod_upd
);

    logic ss_act, ss_fall, ss_rise, sck_rise, sck_fall, mosi_s;

    jtframe_spi_sync #(.SYNC(SYNC)) u_sync (
        .clk      (clk),
        .rst      (rst),
        .spi_ss_n (spi_ss_n),
        .spi_sck  (spi_sck),
        .spi_mosi (spi_mosi),
        .ss_act   (ss_act),
        .ss_fall  (ss_fall),
        .ss_rise  (ss_rise),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .mosi_s   (mosi_s)
    );

    state_t          state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [2:0]      byte_cnt_q, byte_cnt_d;
    logic [6:0]      byte_sr_q, byte_sr_d;
    logic [7:0]      cmd_q, cmd_d;
    logic [ST_W-1:0] shadow_q, shadow_d;
    logic [ST_W-1:0] rd_sr_q, rd_sr_d;
    logic            commit_q, commit_d;
    logic            miso_q, miso_d;
    logic [ST_W-1:0] status_q, status_d;
    logic [6:0]      core_mod_q, core_mod_d;
    logic            status_upd_q, status_upd_d;
    logic            mod_upd_q, mod_upd_d;

    logic [7:0]      full_byte;
    logic [ST_W-1:0] st_new;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            bit_cnt_q    <= '0;
            byte_cnt_q   <= '0;
            byte_sr_q    <= '0;
            cmd_q        <= '0;
            shadow_q     <= '0;
            rd_sr_q      <= '0;
            commit_q     <= 1'b0;
            miso_q       <= 1'b0;
            status_q     <= '0;
            core_mod_q   <= MOD_DEF;
            status_upd_q <= 1'b0;
            mod_upd_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            byte_sr_q    <= byte_sr_d;
            cmd_q        <= cmd_d;
            shadow_q     <= shadow_d;
            rd_sr_q      <= rd_sr_d;
            commit_q     <= commit_d;
            miso_q       <= miso_d;
            status_q     <= status_d;
            core_mod_q   <= core_mod_d;
            status_upd_q <= status_upd_d;
            mod_upd_q    <= mod_upd_d;
        end
    end

    assign full_byte = {byte_sr_q, mosi_s};

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        byte_sr_d    = byte_sr_q;
        cmd_d        = cmd_q;
        shadow_d     = shadow_q;
        rd_sr_d      = rd_sr_q;
        commit_d     = 1'b0;
        miso_d       = miso_q;
        status_d     = status_q;
        core_mod_d   = core_mod_q;
        status_upd_d = 1'b0;
        mod_upd_d    = 1'b0;
        st_new       = status_q;

        if (commit_q) begin
            case (cmd_q)
                CMD_ST64: st_new = shadow_q;
                CMD_ST32: st_new = {status_q[ST_W-1:32], shadow_q[31:0]};
                default:  st_new = status_q;
            endcase
            status_d     = st_new;
            status_upd_d = (st_new != status_q);
            if (cmd_q == CMD_MOD) begin
                core_mod_d = shadow_q[6:0];
                mod_upd_d  = 1'b1;
            end
        end

        if (sck_rise && state_q != S_IDLE) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            byte_sr_d = full_byte[6:0];
        end

        case (state_q)
            S_IDLE: begin
                if (ss_fall) begin
                    state_d   = S_CMD;
                    bit_cnt_d = '0;
                    shadow_d  = '0;
                end
            end
            S_CMD: begin
                if (sck_rise && bit_cnt_q == 3'd7) begin
                    cmd_d      = full_byte;
                    byte_cnt_d = '0;
                    case (full_byte)
                        CMD_ST32, CMD_ST64, CMD_MOD: state_d = S_WR;
                        CMD_STRD: begin
                            state_d = S_RD;
                            rd_sr_d = byte_swap(status_q);
                            miso_d  = status_q[7];
                        end
                        default: state_d = S_IGNORE;
                    endcase
                end
            end
            S_WR: begin
                if (sck_rise && bit_cnt_q == 3'd7) begin
                    shadow_d[{byte_cnt_q, 3'b000} +: 8] = full_byte;
                    byte_cnt_d = byte_cnt_q + 3'd1;
                    if (byte_cnt_q == last_byte(cmd_q)) begin
                        commit_d = 1'b1;
                        state_d  = S_IGNORE;
                    end
                end
            end
            S_RD: begin
                // Master samples on rise; pre-shift so the next fall presents the following bit.
                if (sck_rise) begin
                    rd_sr_d = {rd_sr_q[ST_W-2:0], 1'b0};
                    if (bit_cnt_q == 3'd7) begin
                        byte_cnt_d = byte_cnt_q + 3'd1;
                        if (byte_cnt_q == 3'd7) state_d = S_IGNORE;
                    end
                end
                if (sck_fall) miso_d = rd_sr_q[ST_W-1];
            end
            default: ;
        endcase

        // Applied after the SCK handling so a coincident final edge still commits.
        if (ss_rise) state_d = S_IDLE;

        if (state_d != S_RD || !ss_act) miso_d = 1'b0;
    end

    assign spi_miso   = miso_q;
    assign status     = status_q;
    assign core_mod   = core_mod_q;
    assign status_upd = status_upd_q;
    assign mod_upd    = mod_upd_q;

endmodule

// File: tb/tb_jtframe_status_spi.sv
// Directed self-checking bench for jtframe_status_spi with a slow bit-banged SPI master.
module tb_jtframe_status_spi;

    localparam int HP = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        spi_ss_n;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_miso;
    logic [63:0] status;
    logic [6:0]  core_mod;
    logic        status_upd;
    logic        mod_upd;

    int total = 0;
    int bad   = 0;
    int n_supd = 0;
    int n_mupd = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (status_upd) n_supd <= n_supd + 1;
        if (mod_upd)    n_mupd <= n_mupd + 1;
    end

    jtframe_status_spi dut (
        .clk        (clk),
        .rst        (rst),
        .spi_ss_n   (spi_ss_n),
        .spi_sck    (spi_sck),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .status     (status),
        .core_mod   (core_mod),
        .status_upd (status_upd),
        .mod_upd    (mod_upd)
    );

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bit(input logic b, output logic m);
        spi_mosi = b;
        cyc(HP);
        m = spi_miso;
        spi_sck = 1'b1;
        cyc(HP);
        spi_sck = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] b, output logic [7:0] m);
        logic x;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(b[i], x);
            m[i] = x;
        end
    endtask

    task automatic spi_start();
        spi_ss_n = 1'b0;
        cyc(HP);
    endtask

    task automatic spi_stop();
        cyc(HP);
        spi_ss_n = 1'b1;
        cyc(2*HP);
    endtask

    task automatic send(input logic [7:0] cmd, input logic [63:0] data, input int nbytes);
        logic [7:0] m;
        spi_start();
        spi_byte(cmd, m);
        for (int k = 0; k < nbytes; k++) spi_byte(data[8*k +: 8], m);
        spi_stop();
    endtask

    task automatic test_reset();
        rst = 1'b1; spi_ss_n = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0;
        cyc(4);
        rst = 1'b0;
        cyc(4);
        total++; if (status !== 64'h0) begin bad++; $display("FAIL reset_status got=%h exp=%h", status, 64'h0); end
        total++; if (core_mod !== 7'h00) begin bad++; $display("FAIL reset_core_mod got=%h exp=%h", core_mod, 7'h00); end
        total++; if ({status_upd, mod_upd} !== 2'b00) begin bad++; $display("FAIL reset_pulses got=%b exp=00", {status_upd, mod_upd}); end
        total++; if (spi_miso !== 1'b0) begin bad++; $display("FAIL reset_miso got=%b exp=0", spi_miso); end
    endtask

    task automatic test_st64_latency();
        logic [7:0] m;
        logic       x;
        int         s0;
        s0 = n_supd;
        spi_start();
        spi_byte(8'h1E, m);
        for (int k = 1; k <= 7; k++) spi_byte(8'(k), m);
        for (int i = 7; i >= 1; i--) spi_bit(1'b0 | ((i == 3) ? 1'b1 : 1'b0), x);
        spi_mosi = 1'b0;
        cyc(HP);
        spi_sck = 1'b1;
        cyc(3);
        total++; if (status !== 64'h0) begin bad++; $display("FAIL st64_early got=%h exp=%h", status, 64'h0); end
        cyc(1);
        total++; if (status !== 64'h0807060504030201) begin bad++; $display("FAIL st64_value got=%h exp=%h", status, 64'h0807060504030201); end
        total++; if (status_upd !== 1'b1) begin bad++; $display("FAIL st64_upd_aligned got=%b exp=1", status_upd); end
        cyc(HP-4);
        spi_sck = 1'b0;
        spi_stop();
        total++; if (n_supd - s0 !== 1) begin bad++; $display("FAIL st64_upd_count got=%0d exp=1", n_supd - s0); end
    endtask

    task automatic test_st32();
        int s0;
        s0 = n_supd;
        send(8'h14, 64'h00000000DDCCBBAA, 4);
        total++; if (status !== 64'h08070605DDCCBBAA) begin bad++; $display("FAIL st32_value got=%h exp=%h", status, 64'h08070605DDCCBBAA); end
        total++; if (n_supd - s0 !== 1) begin bad++; $display("FAIL st32_upd_count got=%0d exp=1", n_supd - s0); end
    endtask

    task automatic test_mod_and_equal();
        int s0, m0;
        m0 = n_mupd; s0 = n_supd;
        send(8'h21, 64'hFF, 1);
        total++; if (core_mod !== 7'h7F) begin bad++; $display("FAIL mod_value got=%h exp=%h", core_mod, 7'h7F); end
        total++; if (n_mupd - m0 !== 1) begin bad++; $display("FAIL mod_upd_count got=%0d exp=1", n_mupd - m0); end
        m0 = n_mupd;
        send(8'h21, 64'hFF, 1);
        total++; if (n_mupd - m0 !== 1) begin bad++; $display("FAIL mod_repeat_upd got=%0d exp=1", n_mupd - m0); end
        total++; if (n_supd - s0 !== 0) begin bad++; $display("FAIL mod_no_status_upd got=%0d exp=0", n_supd - s0); end
        s0 = n_supd;
        send(8'h1E, 64'h08070605DDCCBBAA, 8);
        total++; if (status !== 64'h08070605DDCCBBAA) begin bad++; $display("FAIL equal_value got=%h exp=%h", status, 64'h08070605DDCCBBAA); end
        total++; if (n_supd - s0 !== 0) begin bad++; $display("FAIL equal_no_upd got=%0d exp=0", n_supd - s0); end
    endtask

    task automatic test_abort();
        logic [7:0] m;
        int s0, m0;
        s0 = n_supd; m0 = n_mupd;
        spi_start();
        spi_byte(8'h1E, m);
        for (int k = 0; k < 5; k++) spi_byte(8'h11 + 8'(k), m);
        spi_stop();
        total++; if (status !== 64'h08070605DDCCBBAA) begin bad++; $display("FAIL abort_value got=%h exp=%h", status, 64'h08070605DDCCBBAA); end
        total++; if ((n_supd - s0) + (n_mupd - m0) !== 0) begin bad++; $display("FAIL abort_pulses got=%0d exp=0", (n_supd - s0) + (n_mupd - m0)); end
        send(8'h1E, 64'h1817161514131211, 8);
        total++; if (status !== 64'h1817161514131211) begin bad++; $display("FAIL after_abort got=%h exp=%h", status, 64'h1817161514131211); end
    endtask

    task automatic test_readback();
        logic [7:0]  m;
        logic [63:0] rx;
        rx = '0;
        spi_start();
        spi_byte(8'h1F, m);
        for (int k = 0; k < 8; k++) begin
            spi_byte(8'h00, m);
            rx[8*k +: 8] = m;
        end
        spi_stop();
        total++; if (rx !== 64'h1817161514131211) begin bad++; $display("FAIL readback got=%h exp=%h", rx, 64'h1817161514131211); end
        total++; if (spi_miso !== 1'b0) begin bad++; $display("FAIL miso_after_ss got=%b exp=0", spi_miso); end
    endtask

    task automatic test_unknown_and_extra();
        int s0, m0;
        s0 = n_supd; m0 = n_mupd;
        send(8'h55, 64'hA5A5_5A5A_0F0F_F0F0, 8);
        total++; if (status !== 64'h1817161514131211) begin bad++; $display("FAIL unknown_status got=%h exp=%h", status, 64'h1817161514131211); end
        total++; if (core_mod !== 7'h7F) begin bad++; $display("FAIL unknown_mod got=%h exp=%h", core_mod, 7'h7F); end
        total++; if ((n_supd - s0) + (n_mupd - m0) !== 0) begin bad++; $display("FAIL unknown_pulses got=%0d exp=0", (n_supd - s0) + (n_mupd - m0)); end
        s0 = n_supd;
        send(8'h14, 64'h000000FF04030201, 5);
        total++; if (status !== 64'h1817161504030201) begin bad++; $display("FAIL extra_value got=%h exp=%h", status, 64'h1817161504030201); end
        total++; if (n_supd - s0 !== 1) begin bad++; $display("FAIL extra_single_commit got=%0d exp=1", n_supd - s0); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] m;
        int s0, m0;
        spi_start();
        spi_byte(8'h1E, m);
        for (int k = 0; k < 3; k++) spi_byte(8'hC0 + 8'(k), m);
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        s0 = n_supd; m0 = n_mupd;
        for (int k = 0; k < 5; k++) spi_byte(8'hE0 + 8'(k), m);
        spi_stop();
        total++; if (status !== 64'h0) begin bad++; $display("FAIL rstmid_status got=%h exp=%h", status, 64'h0); end
        total++; if (core_mod !== 7'h00) begin bad++; $display("FAIL rstmid_mod got=%h exp=%h", core_mod, 7'h00); end
        total++; if ((n_supd - s0) + (n_mupd - m0) !== 0) begin bad++; $display("FAIL rstmid_pulses got=%0d exp=0", (n_supd - s0) + (n_mupd - m0)); end
        send(8'h14, 64'h0C0B0A09, 4);
        total++; if (status !== 64'h000000000C0B0A09) begin bad++; $display("FAIL post_reset_frame got=%h exp=%h", status, 64'h000000000C0B0A09); end
    endtask

    initial begin
        rst = 1'b1; spi_ss_n = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0;
        test_reset();
        test_st64_latency();
        test_st32();
        test_mod_and_equal();
        test_abort();
        test_readback();
        test_unknown_and_extra();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
